// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator with a chunked carry-propagate resolve stage.
// Optional build macro CSA_ACC_SATURATE_EN clamps out_data to all-ones on overflow.
module csa_stream_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CPA_CHUNK = 4,
    parameter int COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic [COUNT_W-1:0]   out_count,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NCHUNK = ACC_WIDTH / CPA_CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ACC_WIDTH-1:0] s_reg;
    logic [ACC_WIDTH-1:0] c_reg;
    logic [ACC_WIDTH-1:0] res_reg;
    logic                 ovf_reg;
    logic [COUNT_W-1:0]   count_reg;
    logic [IDX_W-1:0]     chunk_idx;
    logic                 chunk_carry;

    logic [ACC_WIDTH-1:0] x;
    logic [ACC_WIDTH-1:0] maj;
    logic [CPA_CHUNK:0]   chunk_sum;
    int                   chunk_base;
    logic                 accept;
    logic                 deliver;
    logic                 last_chunk;

    // Full-adder row for the incoming operand and one chunk of the final adder.
    always_comb begin
        x          = ACC_WIDTH'(in_data);
        maj        = (s_reg & c_reg) | (s_reg & x) | (c_reg & x);
        chunk_base = int'(chunk_idx) * CPA_CHUNK;
        chunk_sum  = {1'b0, s_reg[chunk_base +: CPA_CHUNK]}
                   + {1'b0, c_reg[chunk_base +: CPA_CHUNK]}
                   + (CPA_CHUNK + 1)'(chunk_carry);
        last_chunk = (chunk_idx == IDX_W'(NCHUNK - 1));
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        state_next = state;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                if (last_chunk) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
        accept  = in_valid & in_ready;
        deliver = out_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            s_reg       <= '0;
            c_reg       <= '0;
            res_reg     <= '0;
            ovf_reg     <= 1'b0;
            count_reg   <= '0;
            chunk_idx   <= '0;
            chunk_carry <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s_reg     <= s_reg ^ c_reg ^ x;
                        c_reg     <= maj << 1;
                        // A carry leaving the top bit is 2^ACC_WIDTH lost for good.
                        ovf_reg   <= ovf_reg | maj[ACC_WIDTH-1];
                        count_reg <= count_reg + COUNT_W'(1);
                        if (in_last) begin
                            chunk_idx   <= '0;
                            chunk_carry <= 1'b0;
                            res_reg     <= '0;
                        end
                    end
                end
                RESOLVE: begin
                    res_reg[chunk_base +: CPA_CHUNK] <= chunk_sum[CPA_CHUNK-1:0];
                    chunk_carry <= chunk_sum[CPA_CHUNK];
                    chunk_idx   <= chunk_idx + IDX_W'(1);
                    if (last_chunk) begin
                        ovf_reg <= ovf_reg | chunk_sum[CPA_CHUNK];
                    end
                end
                OUTPUT: begin
                    if (deliver) begin
                        s_reg     <= '0;
                        c_reg     <= '0;
                        ovf_reg   <= 1'b0;
                        count_reg <= '0;
                    end
                end
                default: begin
                    s_reg <= '0;
                    c_reg <= '0;
                end
            endcase
        end
    end

    always_comb begin
`ifdef CSA_ACC_SATURATE_EN
        out_data = ovf_reg ? {ACC_WIDTH{1'b1}} : res_reg;
`else
        out_data = res_reg;
`endif
        out_ovf   = ovf_reg;
        out_count = count_reg;
    end

endmodule
